// File: rtl/fft_frame_buffer.sv
// Ping-pong frame buffer ahead of the FFT core. Two banks of FRAME_LEN samples:
// one bank fills from the sample stream while the other one replays as a
// valid/ready stream with tlast. The readout can be natural or bit-reversed.
module fft_frame_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAME_LEN  = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  request,
  input  logic                  bit_rev,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_tlast,
  input  logic                  out_ready,
  output logic                  overflow,
  output logic [CNT_WIDTH-1:0]  frame_cnt
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] PRIME  = 2'd1;
  localparam logic [1:0] STREAM = 2'd2;

  logic [DATA_WIDTH-1:0] mem [2*FRAME_LEN];
  logic [DATA_WIDTH-1:0] ram_q;

  logic [1:0]            state;
  logic                  wr_bank, rd_bank;
  logic [ADDR_WIDTH-1:0] wr_cnt;
  // rd_cnt is the index of the next RAM read; it runs one past the last index
  logic [ADDR_WIDTH:0]   rd_cnt;
  logic [1:0]            bank_full;
  logic                  rev_q;

  logic                  wr_en, wr_last, hs, last_hs, rd_done, rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [1:0]            set_mask, free_mask;

  function automatic logic [ADDR_WIDTH-1:0] bit_reverse(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] r;
    for (int i = 0; i < ADDR_WIDTH; i++) r[i] = a[ADDR_WIDTH-1-i];
    return r;
  endfunction

  // Handshake and RAM-port decode
  always_comb begin
    in_ready  = request & ~bank_full[wr_bank] & rst_n;
    wr_en     = in_valid & in_ready;
    wr_last   = wr_en & (wr_cnt == ADDR_WIDTH'(FRAME_LEN - 1));
    hs        = (state == STREAM) & out_valid & out_ready;
    last_hs   = hs & out_tlast;
    rd_done   = (rd_cnt == (ADDR_WIDTH+1)'(FRAME_LEN));
    // a read is issued only when the output register will take the word
    rd_en     = ((state == IDLE) & bank_full[rd_bank]) | (state == PRIME) |
                (hs & ~out_tlast & ~rd_done);
    rd_addr   = rev_q ? bit_reverse(rd_cnt[ADDR_WIDTH-1:0]) : rd_cnt[ADDR_WIDTH-1:0];
    set_mask  = wr_last ? (2'b01 << wr_bank) : 2'b00;
    free_mask = last_hs ? (2'b01 << rd_bank) : 2'b00;
  end

  // Sample RAM: one write port, one synchronous read port (not reset)
  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_bank, wr_cnt}] <= in_data;
    if (rd_en) ram_q <= mem[{rd_bank, rd_addr}];
  end

  // Write side: fill position, bank ownership flags and sticky overflow
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_bank   <= 1'b0;
      wr_cnt    <= '0;
      bank_full <= 2'b00;
      overflow  <= 1'b0;
    end else begin
      if (!request) begin
        wr_cnt <= '0;
      end else if (wr_en) begin
        if (wr_last) begin
          wr_cnt  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end
      if (request & in_valid & ~in_ready) overflow <= 1'b1;
      // fill and free always target different banks, so both can land together
      bank_full <= (bank_full & ~free_mask) | set_mask;
    end
  end

  // Read FSM: prime the output register, then stream under backpressure
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_bank   <= 1'b0;
      rd_cnt    <= '0;
      rev_q     <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_tlast <= 1'b0;
      frame_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bank_full[rd_bank]) begin
            rev_q  <= bit_rev;
            rd_cnt <= (ADDR_WIDTH+1)'(1);
            state  <= PRIME;
          end
        end
        PRIME: begin
          out_data  <= ram_q;
          out_valid <= 1'b1;
          out_tlast <= 1'b0;
          rd_cnt    <= rd_cnt + 1'b1;
          state     <= STREAM;
        end
        STREAM: begin
          if (hs) begin
            if (out_tlast) begin
              out_valid <= 1'b0;
              out_tlast <= 1'b0;
              rd_bank   <= ~rd_bank;
              rd_cnt    <= '0;
              frame_cnt <= frame_cnt + CNT_WIDTH'(1);
              state     <= IDLE;
            end else begin
              // word loaded now is sample rd_cnt-1 of the frame
              out_data  <= ram_q;
              out_tlast <= rd_done;
              if (!rd_done) rd_cnt <= rd_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Bench for fft_frame_buffer with FRAME_LEN=8: a frame-level reference model
// (sample queues and a full-frame count) checked every cycle, plus literal
// expectations for latency, bit-reversed order and reset.
module tb_fft_frame_buffer;
  localparam int DW = 32;
  localparam int FL = 8;
  localparam int AW = 3;
  localparam int CW = 16;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          request = 0, bit_rev = 0, in_valid = 0, out_ready = 0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_valid, out_tlast, overflow;
  logic [DW-1:0] out_data;
  logic [CW-1:0] frame_cnt;

  fft_frame_buffer #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .request(request), .bit_rev(bit_rev),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_tlast(out_tlast),
    .out_ready(out_ready), .overflow(overflow), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model state
  logic [DW-1:0] part[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got[$];
  int            nfull = 0;
  int            emit_pos = 0;
  logic          ovf_m = 0;
  logic [CW-1:0] fc_m = '0;
  logic          stall_prev = 0;
  logic [DW-1:0] prev_data;
  logic          prev_tlast;
  logic          mon_en = 0;

  function automatic int brev3(input int i);
    return ((i & 1) << 2) | (i & 2) | ((i >> 2) & 1);
  endfunction

  // Compare DUT against the model, then advance the model across the coming edge
  always @(negedge clk) begin
    if (mon_en) begin
      chk("in_ready", in_ready, rst_n && request && (nfull < 2));
      chk("overflow", overflow, ovf_m);
      chk("frame_cnt", frame_cnt, fc_m);
      if (stall_prev) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_data", out_data, prev_data);
        chk("hold_tlast", out_tlast, prev_tlast);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) chk("spurious_valid", 1'b1, 1'b0);
        else begin
          chk("out_data", out_data, exp_q[0]);
          chk("out_tlast", out_tlast, emit_pos == FL-1);
        end
      end else begin
        chk("tlast_idle", out_tlast, 1'b0);
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      prev_tlast = out_tlast;
      if (!rst_n) begin
        part.delete(); exp_q.delete();
        nfull = 0; emit_pos = 0; ovf_m = 0; fc_m = '0; stall_prev = 0;
      end else begin
        // acceptance uses occupancy before this edge's frame release
        if (!request) part.delete();
        else if (in_valid) begin
          if (nfull < 2) begin
            part.push_back(in_data);
            if (part.size() == FL) begin
              for (int i = 0; i < FL; i++) exp_q.push_back(part[bit_rev ? brev3(i) : i]);
              nfull++;
              part.delete();
            end
          end else ovf_m = 1;
        end
        if (out_valid && out_ready && exp_q.size() > 0) begin
          got.push_back(out_data);
          void'(exp_q.pop_front());
          if (emit_pos == FL-1) begin
            emit_pos = 0; nfull--; fc_m = fc_m + 1'b1;
          end else emit_pos++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic write_seq(input int first, input int n);
    for (int v = first; v < first + n; v++) begin
      in_data = DW'(v); in_valid = 1; tick();
    end
    in_valid = 0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin tick(); n++; end
    if (n >= 300) chk("drain_timeout", 1'b0, 1'b1);
  endtask

  logic [DW-1:0] rev_exp [FL] = '{0, 4, 2, 6, 1, 5, 3, 7};

  initial begin
    // reset
    tick(); mon_en = 1; tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_frame_cnt", frame_cnt, '0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    rst_n = 1; request = 1; out_ready = 1; tick();

    // 1: natural order, latency and no gaps
    write_seq(1, 8);
    chk("lat_e0", out_valid, 1'b0); tick();
    chk("lat_e1", out_valid, 1'b0); tick();
    chk("lat_e2_valid", out_valid, 1'b1);
    chk("lat_e2_data", out_data, 1);
    for (int k = 2; k <= 8; k++) begin
      tick();
      chk("gapless_valid", out_valid, 1'b1);
      chk("gapless_data", out_data, DW'(k));
      chk("tlast_lit", out_tlast, k == 8);
    end
    tick();
    chk("fc1_lit", frame_cnt, 1);
    chk("drop_valid", out_valid, 1'b0);

    // 2: bit-reversed order
    got.delete(); bit_rev = 1;
    write_seq(0, 8); wait_drain();
    chk("rev_count", got.size(), FL);
    for (int i = 0; i < FL; i++) chk("rev_lit", got[i], rev_exp[i]);
    bit_rev = 0;

    // 3: backpressure, stall and overflow
    got.delete(); out_ready = 0;
    write_seq(1, 16);
    chk("stall_in_ready", in_ready, 1'b0);
    in_data = 17; in_valid = 1; tick(); in_valid = 0;
    chk("ovf_lit", overflow, 1'b1);
    out_ready = 1; wait_drain();
    chk("bp_count", got.size(), 16);
    for (int i = 0; i < 16 && i < got.size(); i++) chk("bp_lit", got[i], DW'(i + 1));

    // 4: toggling out_ready over two frames
    got.delete();
    fork
      write_seq(1, 16);
      for (int c = 0; c < 40; c++) begin out_ready = ~out_ready; tick(); end
    join
    out_ready = 1; wait_drain();
    chk("tog_count", got.size(), 16);

    // 5: partial frame abort
    got.delete();
    write_seq(100, 5);
    request = 0; tick(); request = 1;
    write_seq(11, 8); wait_drain();
    chk("abort_count", got.size(), FL);
    for (int i = 0; i < FL && i < got.size(); i++) chk("abort_lit", got[i], DW'(11 + i));

    // 6: reset during readout, then a fresh frame
    write_seq(1, 8);
    for (int c = 0; c < 4; c++) tick();
    rst_n = 0; tick(); rst_n = 1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_data", out_data, '0);
    chk("mid_rst_tlast", out_tlast, 1'b0);
    chk("mid_rst_fc", frame_cnt, '0);
    chk("mid_rst_ovf", overflow, 1'b0);
    got.delete();
    write_seq(21, 8); wait_drain();
    chk("fresh_count", got.size(), FL);
    for (int i = 0; i < FL && i < got.size(); i++) chk("fresh_lit", got[i], DW'(21 + i));
    chk("fresh_fc", frame_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/fft_frame_buffer.md
Name: fft_frame_buffer

Overview:
Single-clock, parametrised ping-pong frame buffer that collects streaming samples into FFT-length frames and replays each frame as a valid/ready stream with tlast. It replaces the fixed-depth, output-only-valid FIFO used ahead of the FFT core. New capabilities: two-bank buffering, downstream backpressure, selectable bit-reversed readout order, overflow detection and a frame counter. It sits between the sample source and the FFT butterfly input.

Parameters:
DATA_WIDTH, 32, sample width in bits
FRAME_LEN, 32, samples per frame and per bank; power of 2, >= 4
ADDR_WIDTH, 5, log2(FRAME_LEN); must be consistent with FRAME_LEN
CNT_WIDTH, 16, width of frame_cnt

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  synchronous active-low reset
request  in  1  capture enable; 0 aborts the partial frame being written
bit_rev  in  1  readout order for the next frame: 0 natural, 1 bit-reversed
in_data  in  DATA_WIDTH  input sample
in_valid  in  1  input sample valid
in_ready  out  1  buffer can accept in_data this cycle
out_data  out  DATA_WIDTH  output sample
out_valid  out  1  out_data valid
out_tlast  out  1  last sample of the frame
out_ready  in  1  downstream accepts out_data
overflow  out  1  sticky: a sample was offered while capture was stalled
frame_cnt  out  CNT_WIDTH  number of frames fully emitted; wraps modulo 2^CNT_WIDTH

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs are 0; wr_bank=rd_bank=0; wr_cnt=rd_cnt=0; both bank_full bits=0; read FSM=IDLE. RAM contents are not reset.
- Storage: 2 banks x FRAME_LEN words; synchronous-read RAM with 1-cycle read latency.
- Write side:
  - in_ready = request & ~bank_full[wr_bank] & rst_n. It is combinational from registers and request.
  - A write occurs on in_valid & in_ready: mem[wr_bank][wr_cnt] <= in_data, and wr_cnt increments.
  - At wr_cnt = FRAME_LEN-1, the write also sets bank_full[wr_bank]=1, toggles wr_bank and clears wr_cnt.
  - request=0 at an edge clears wr_cnt, discarding the partial frame. Full banks are unaffected.
  - overflow <= 1 on any edge with request & in_valid & ~in_ready. It is cleared only by reset.
- Read FSM states are IDLE, PRIME and STREAM.
  - IDLE: when bank_full[rd_bank]=1, latch bit_rev into rev_q, issue a RAM read at index 0, and go to PRIME.
  - PRIME: the RAM output loads the output register. out_valid becomes 1, and the read at index 1 is issued. Go to STREAM.
  - STREAM: on out_valid & out_ready, the output register takes the next RAM word and rd_cnt advances. The next read is issued only when the output register is being consumed. With out_ready=0, out_data, out_valid and out_tlast hold stable.
  - Read address = rev_q ? bit-reverse(rd_cnt[ADDR_WIDTH-1:0]) : rd_cnt.
  - out_tlast = 1 exactly while the FRAME_LEN-th sample of the frame is presented.
  - On the tlast handshake: clear bank_full[rd_bank], toggle rd_bank, increment frame_cnt and return to IDLE. out_valid drops the next cycle unless PRIME follows.
- Latency:
  - The last write of a frame at edge N sets bank_full.
  - IDLE sees it at edge N+1. out_valid=1 after edge N+2 with sample 0.
  - With out_ready held at 1, one sample is emitted per cycle with no gaps inside a frame.
  - There are 2 idle cycles between back-to-back frames.
- Simultaneous events:
  - The write side filling a bank and the read side freeing the other bank on the same edge both take effect.
  - A write may not target a full bank, because in_ready guards it.
  - If the read side frees the bank the writer is stalled on, in_ready rises the cycle after the tlast handshake.
- bit_rev changes mid-frame have no effect until the next frame start.
- Reset mid-operation takes effect at the next edge. All frames are discarded and outputs go to 0.

Test Plan:
- FRAME_LEN=8, out_ready=1, request=1. Write 1..8 on consecutive cycles. Required: out_data 1..8 on 8 consecutive cycles, first out_valid 2 edges after the 8th write, out_tlast only with 8, frame_cnt=1.
- bit_rev=1, write 0..7. Required: out_data 0,4,2,6,1,5,3,7 with tlast on 7.
- out_ready=0, write 1..16. Required: in_ready=0 after the 16th write; a 17th sample with in_valid=1 sets overflow=1. Then raise out_ready. Required: 1..16 emitted, tlast on 8 and 16, in_ready=1 the cycle after the sample-8 handshake.
- out_ready toggled every cycle over 2 frames (1..16). Required: no loss or duplication, and out_data stable during every out_valid & ~out_ready cycle.
- Write 5 samples, drop request for 1 cycle, then write 11..18. Required: output frame 11..18, and the first 5 samples never appear.
- rst_n=0 for 1 cycle in the middle of frame readout. Required: all outputs 0 the next cycle, frame_cnt=0, overflow=0. A fresh 8-sample frame then streams out normally.
